// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display blocks.
package seg7_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex-to-segment table, {g,f,e,d,c,b,a}, active-high. Element k decodes value k.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Table lookup; every 4-bit value has an entry.
  always_comb begin
    seg = SEG_TABLE[value];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-cathode 7-segment digits.
// A double-buffered value table is swapped only at frame wrap so a frame never tears.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SlotLast  = CW'(SLOT_CYCLES - 1);
  // BLANK is unreachable when BLANK_CYCLES is 0, so its compare value is irrelevant then.
  localparam logic [CW-1:0] BlankLast = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DigitLast = DW'(NUM_DIGITS - 1);
  localparam state_e        SlotStart = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_e                  state_q, state_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                    pending_q, pending_d;
  logic                    ready_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    fd_q, fd_d;
  logic                    xfer;
  logic [3:0]              nib;
  logic [6:0]              dec_seg;

  assign xfer       = load_valid & ready_q;
  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign seg_dp     = dp_q;
  assign digit_en   = en_q;
  assign frame_done = fd_q;

  // Next-state: scan sequencing, handshake and table double-buffering.
  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    pending_d  = pending_q;
    fd_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          act_data_d = load_data;
          act_dp_d   = load_dp;
        end
        if (enable) begin
          state_d = SlotStart;
          dig_d   = '0;
          cnt_d   = '0;
        end
      end
      BLANK, SHOW: begin
        if (!enable) begin
          state_d = IDLE;
          if (pending_q) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            pending_d  = 1'b0;
          end
          // Display goes dark anyway, so a load on this edge lands straight in the active table.
          if (xfer) begin
            act_data_d = load_data;
            act_dp_d   = load_dp;
          end
        end else begin
          if (xfer) begin
            sh_data_d = load_data;
            sh_dp_d   = load_dp;
            pending_d = 1'b1;
          end
          if (state_q == BLANK) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BlankLast) state_d = SHOW;
          end else if (cnt_q == SlotLast) begin
            cnt_d   = '0;
            state_d = SlotStart;
            if (dig_q == DigitLast) begin
              dig_d = '0;
              fd_d  = 1'b1;
              // pending_q and xfer are exclusive, so a wrap-edge load stays pending.
              if (pending_q) begin
                act_data_d = sh_data_q;
                act_dp_d   = sh_dp_q;
                pending_d  = 1'b0;
              end
            end else begin
              dig_d = dig_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state so they register on the same edge as the state.
  always_comb begin
    nib  = act_data_d[{dig_d, 2'b00} +: 4];
    en_d = '0;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (state_d == SHOW) begin
      en_d  = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << dig_d;
      seg_d = dec_seg;
      dp_d  = act_dp_d[dig_d];
    end
  end

  seg7_hex_decoder u_dec (
    .value (nib),
    .seg   (dec_seg)
  );

  // State, tables and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dig_q      <= '0;
      cnt_q      <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
      en_q       <= '0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      pending_q  <= pending_d;
      ready_q    <= ~pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      en_q       <= en_d;
      fd_q       <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seg7_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;
  localparam int unsigned BC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [6:0] ref_seg(logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_cyc(input logic [3:0] en, input logic [6:0] s, input logic dp,
                          input logic fd);
    exp_t e;
    e.en  = en;
    e.seg = s;
    e.dp  = dp;
    e.fd  = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_slot(input int d, input logic [3:0] nib, input logic dp, input logic fd);
    push_cyc(4'b0000, 7'h00, 1'b0, fd);
    repeat (SC - BC) push_cyc(4'b0001 << d, ref_seg(nib), dp, 1'b0);
  endtask

  task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic fd);
    for (int k = 0; k < 4; k++) push_slot(k, d[4*k +: 4], p[k], (k == 0) ? fd : 1'b0);
  endtask

  // One clock: sample after the edge and compare against the next scoreboard entry.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    check_val("onehot0", {31'd0, $onehot0(digit_en)}, 32'd1);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("digit_en", {28'd0, digit_en}, {28'd0, e.en});
      check_val("seg", {25'd0, seg}, {25'd0, e.seg});
      check_val("seg_dp", {31'd0, seg_dp}, {31'd0, e.dp});
      check_val("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
    end
  endtask

  initial begin
    logic [15:0] shown;
    logic [3:0]  shown_dp;
    logic [15:0] nd;
    logic [3:0]  b;

    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    #12;
    check_val("rst_digit_en", {28'd0, digit_en}, 32'd0);
    check_val("rst_seg", {25'd0, seg}, 32'd0);
    check_val("rst_seg_dp", {31'd0, seg_dp}, 32'd0);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_val("rst_load_ready", {31'd0, load_ready}, 32'd1);

    // Load while idle, then start scanning.
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h3210;
    load_dp    = 4'b0100;
    push_cyc(4'b0000, 7'h00, 1'b0, 1'b0);
    step();
    check_val("idle_load_ready", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b0;
    enable     = 1'b1;
    push_frame(16'h3210, 4'b0100, 1'b0);
    repeat (16) step();
    push_frame(16'h3210, 4'b0100, 1'b1);
    repeat (16) step();

    // Mid-frame load during digit 1; a second load is held off until the wrap.
    push_frame(16'h3210, 4'b0100, 1'b1);
    repeat (5) step();
    load_valid = 1'b1;
    load_data  = 16'hCDEF;
    load_dp    = 4'b0001;
    step();
    check_val("mid_load_ready_low", {31'd0, load_ready}, 32'd0);
    load_data = 16'hA5B6;
    load_dp   = 4'b1000;
    repeat (10) step();
    check_val("backpressure_ready_low", {31'd0, load_ready}, 32'd0);
    push_frame(16'hCDEF, 4'b0001, 1'b1);
    step();
    check_val("wrap_ready_high", {31'd0, load_ready}, 32'd1);
    step();
    check_val("held_load_accepted", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    repeat (14) step();

    // Held load shows after the next wrap; drop enable in digit 2's SHOW.
    push_slot(0, 4'h6, 1'b0, 1'b1);
    push_slot(1, 4'hB, 1'b0, 1'b0);
    push_cyc(4'b0000, 7'h00, 1'b0, 1'b0);
    push_cyc(4'b0100, ref_seg(4'h5), 1'b0, 1'b0);
    step();
    check_val("second_wrap_ready", {31'd0, load_ready}, 32'd1);
    repeat (9) step();
    enable = 1'b0;
    push_cyc(4'b0000, 7'h00, 1'b0, 1'b0);
    step();
    enable = 1'b1;
    push_frame(16'hA5B6, 4'b1000, 1'b0);
    repeat (16) step();

    // Asynchronous reset between edges during digit 0's SHOW.
    push_cyc(4'b0000, 7'h00, 1'b0, 1'b1);
    push_cyc(4'b0001, ref_seg(4'h6), 1'b0, 1'b0);
    repeat (2) step();
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_digit_en", {28'd0, digit_en}, 32'd0);
    check_val("async_rst_seg", {25'd0, seg}, 32'd0);
    check_val("async_rst_seg_dp", {31'd0, seg_dp}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("post_rst_ready", {31'd0, load_ready}, 32'd1);
    push_frame(16'h0000, 4'b0000, 1'b0);
    repeat (16) step();

    // Sweep all nibble values; the first load lands on the wrap edge itself.
    shown    = 16'h0000;
    shown_dp = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      b  = 4'(v);
      nd = {b + 4'd3, b + 4'd2, b + 4'd1, b};
      push_frame(shown, shown_dp, 1'b1);
      if (v == 0) begin
        load_valid = 1'b1;
        load_data  = nd;
        load_dp    = b;
        step();
        load_valid = 1'b0;
        check_val("wrap_edge_load", {31'd0, load_ready}, 32'd0);
        repeat (15) step();
      end else begin
        step();
        check_val("sweep_ready", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = nd;
        load_dp    = b;
        step();
        load_valid = 1'b0;
        check_val("sweep_accept", {31'd0, load_ready}, 32'd0);
        repeat (14) step();
      end
      shown    = nd;
      shown_dp = b;
    end
    push_frame(shown, shown_dp, 1'b1);
    repeat (16) step();
    check_val("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
